psdmultiply_acc: RTL and testbench
==================================

Name: psdmultiply_acc

Overview:
- Sequential unsigned shift-add multiply-accumulate unit, one product bit per clock.
- Computes product = multiplicand * multiplier + addend.
- Inverse companion of the sequential restoring divider: feeding it quotient, divisor and rest reconstructs the dividend.
- Sits beside the divider in the Lab2 datapath and serves as its self-check and reconstruction path.

Parameters:
NBITS, 32, operand width; product is 2*NBITS bits wide; NBITS >= 2.

Ports:
clock  input  1  master clock; all state changes on rising edge.
reset  input  1  synchronous reset, active-low (sampled on rising edge of clock).
start  input  1  request a new operation; sampled only when idle.
multiplicand  input  NBITS  operand A; captured on accepted start.
multiplier  input  NBITS  operand B; captured on accepted start.
addend  input  NBITS  operand C, added once at the end; captured on accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; product valid from this cycle onward.
product  output  2*NBITS  result register; holds its value until the next done.

Behaviour:
- Reset (reset==0 at a clock edge) has priority over everything. Results after the edge:
  - state=IDLE, busy=0, done=0, product=0.
  - counter, accumulator and operand registers all cleared.
  - An operation in progress is discarded and no done is produced.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start==1 at edge k: capture the three operands; set acc_hi(NBITS+1 bits)=0 and acc_lo=multiplier; set cnt=0; busy<=1; go to RUN.
  - start==0: stay in IDLE.
- RUN, one iteration per edge:
  - If acc_lo[0]==1, sum = acc_hi + {1'b0,multiplicand}; otherwise sum = acc_hi.
  - Shift {sum, acc_lo} right by one.
  - cnt <= cnt+1.
  - On the edge where cnt==NBITS-1, go to FINISH.
  - RUN therefore spans edges k+1 .. k+NBITS.
- FINISH, edge k+NBITS+1:
  - product <= {acc_hi[NBITS-1:0], acc_lo} + {NBITS'b0, addend_reg}.
  - done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: done is high in the cycle after edge k+NBITS+1, i.e. NBITS+1 clocks after the start edge.
- Throughput: one operation per NBITS+1 clocks. Start may be asserted in the done cycle; since the state is IDLE it is accepted, so back-to-back operations have no gap.
- start while busy==1 is ignored: operands are not recaptured and the result is unaffected. Start is level-sampled only in IDLE, so start held high continuously re-triggers after every done.
- Width rules:
  - The maximum result, (2^N-1)^2 + (2^N-1) = 2^2N - 2^N, fits in 2*NBITS bits, so there is never overflow and no carry out.
  - The RUN adder is NBITS+1 bits wide so that its carry is kept.
- Operand inputs are don't-care outside the start-acceptance cycle.
- product never changes except at FINISH or reset. done and busy are never high simultaneously.
- Zero operands are not special-cased; they take the full latency.

Test Plan:
1. NBITS=32, reset released, start with multiplicand=7, multiplier=5, addend=3 -> busy=1 on the next cycle; done exactly 33 clocks after the start edge; product=38; product holds 38 afterwards.
2. Multiplicand=multiplier=addend=0xFFFFFFFF -> product=0xFFFFFFFF_00000000. Then 0*0x12345678+0 -> product=0, with the full 33-clock latency.
3. Start A: 100*3+1. Pulse start again with 9*9+9 at cycle 10 while busy -> only done for A, product=301. Then start 9*9+9 in A's done cycle -> second done 33 clocks later, product=90.
4. Start 1000*1000+0. Drive reset=0 for one edge at cycle 15 -> busy=0, done=0, product=0 from the next cycle; no done ever appears. A new start after reset=1 completes normally.
5. Divider round-trip with random dividend/divisor (divisor!=0), 1000 iterations: run the divider, then feed quotient, divisor and rest -> product[31:0]==dividend and product[63:32]==0.
6. NBITS=8 instance: 255*255+255 -> product=0xFF00, done 9 clocks after start. Then 13*11+2 -> product=145.

Source files
------------

// File: rtl/psdmultiply_acc_if.sv
// ============================================================================
// psdmultiply_acc_if : request/result bundle of the shift-add multiply-accumulate
// Rev 1.0
// ============================================================================
`default_nettype none

interface psdmultiply_acc_if #(
  parameter int NBITS = 32
);
  logic                 start;
  logic [NBITS-1:0]     multiplicand;
  logic [NBITS-1:0]     multiplier;
  logic [NBITS-1:0]     addend;
  logic                 busy;
  logic                 done;
  logic [2*NBITS-1:0]   product;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output busy, done, product
  );
endinterface

`default_nettype wire

// File: rtl/psdmultiply_acc.sv
// ============================================================================
// psdmultiply_acc : sequential unsigned product = multiplicand*multiplier+addend,
// one multiplier bit per clock.  Rev 1.0
// ============================================================================
`default_nettype none

module psdmultiply_acc #(
  parameter int NBITS = 32
) (
  input  wire logic        clock,
  input  wire logic        reset,
  psdmultiply_acc_if.slave bus
);

  localparam int                CNT_W    = $clog2(NBITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBITS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]           state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [NBITS:0]       acc_hi_q,  acc_hi_d;
  logic [NBITS-1:0]     acc_lo_q,  acc_lo_d;
  logic [NBITS-1:0]     mcand_q,   mcand_d;
  logic [NBITS-1:0]     addend_q,  addend_d;
  logic [2*NBITS-1:0]   product_q, product_d;
  logic                 done_q,    done_d;
  logic [NBITS:0]       sum;
  logic                 busy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      addend_q  <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      addend_q  <= addend_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_RUN;
      S_RUN:    if (cnt_q == CNT_LAST) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    addend_d  = addend_q;
    product_d = product_q;
    done_d    = 1'b0;
    // One bit wider than the operand so the partial-sum carry survives the shift
    sum       = acc_lo_q[0] ? (acc_hi_q + {1'b0, mcand_q}) : acc_hi_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.multiplicand;
          addend_d = bus.addend;
          acc_hi_d = '0;
          acc_lo_d = bus.multiplier;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        acc_hi_d = {1'b0, sum[NBITS:1]};
        acc_lo_d = {sum[0], acc_lo_q[NBITS-1:1]};
        cnt_d    = cnt_q + 1'b1;
      end
      S_FINISH: begin
        product_d = {acc_hi_q[NBITS-1:0], acc_lo_q} + {{NBITS{1'b0}}, addend_q};
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_psdmultiply_acc.sv
// ============================================================================
// tb_psdmultiply_acc : scoreboard bench for 32-bit and 8-bit multiply-accumulate
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_psdmultiply_acc;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  psdmultiply_acc_if #(.NBITS(32)) bus32 ();
  psdmultiply_acc_if #(.NBITS(8))  bus8 ();

  psdmultiply_acc #(.NBITS(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  psdmultiply_acc #(.NBITS(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32;
  exp_t        e8;
  logic [63:0] last32 = '0;
  logic [63:0] last8  = '0;
  int          total  = 0;
  int          bad    = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (mon_en) begin
      check("done_busy32", 64'(bus32.done & bus32.busy), 64'd0);
      if (bus32.done) begin
        if (q32.size() == 0) begin
          check("spurious_done32", 64'd1, 64'd0);
        end else begin
          e32 = q32.pop_front();
          check("product32", bus32.product, e32.prod);
          check("latency32", 64'(cyc), 64'(e32.at));
          last32 = e32.prod;
        end
      end else begin
        check("hold32", bus32.product, last32);
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      check("done_busy8", 64'(bus8.done & bus8.busy), 64'd0);
      if (bus8.done) begin
        if (q8.size() == 0) begin
          check("spurious_done8", 64'd1, 64'd0);
        end else begin
          e8 = q8.pop_front();
          check("product8", 64'(bus8.product), e8.prod);
          check("latency8", 64'(cyc), 64'(e8.at));
          last8 = e8.prod;
        end
      end else begin
        check("hold8", 64'(bus8.product), last8);
      end
    end
  end

  // Called on a falling edge; the following rising edge is the start edge.
  task automatic start32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input bit accept);
    exp_t e;
    bus32.multiplicand = a;
    bus32.multiplier   = b;
    bus32.addend       = c;
    bus32.start        = 1'b1;
    if (accept) begin
      e.prod = 64'(a) * 64'(b) + 64'(c);
      e.at   = cyc + 1 + 33;
      q32.push_back(e);
    end
    @(negedge clock);
    bus32.start = 1'b0;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_t e;
    bus8.multiplicand = a;
    bus8.multiplier   = b;
    bus8.addend       = c;
    bus8.start        = 1'b1;
    e.prod = 64'(a) * 64'(b) + 64'(c);
    e.at   = cyc + 1 + 9;
    q8.push_back(e);
    @(negedge clock);
    bus8.start = 1'b0;
  endtask

  task automatic wait32();
    int n = 0;
    while (q32.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (q32.size() != 0) begin
      check("timeout32", 64'(q32.size()), 64'd0);
      q32.delete();
    end
  endtask

  task automatic wait8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (q8.size() != 0) begin
      check("timeout8", 64'(q8.size()), 64'd0);
      q8.delete();
    end
  endtask

  initial begin
    logic [31:0] dvd;
    logic [31:0] dvs;
    bus32.start = 1'b0; bus32.multiplicand = '0; bus32.multiplier = '0; bus32.addend = '0;
    bus8.start  = 1'b0; bus8.multiplicand  = '0; bus8.multiplier  = '0; bus8.addend  = '0;

    repeat (3) @(negedge clock);
    check("rst_busy32", 64'(bus32.busy), 64'd0);
    check("rst_done32", 64'(bus32.done), 64'd0);
    check("rst_prod32", bus32.product, 64'd0);
    check("rst_prod8", 64'(bus8.product), 64'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);

    // 7*5+3, busy the cycle after start, result held afterwards
    start32(32'd7, 32'd5, 32'd3, 1'b1);
    check("t1_busy", 64'(bus32.busy), 64'd1);
    wait32();
    repeat (3) @(negedge clock);
    check("t1_hold", bus32.product, 64'd38);

    // all-ones corner, then zero operands with full latency
    start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait32();
    check("t2_max", bus32.product, 64'hFFFF_FFFF_0000_0000);
    start32(32'd0, 32'h1234_5678, 32'd0, 1'b1);
    wait32();
    check("t2_zero", bus32.product, 64'd0);

    // start while busy is ignored; start in the done cycle is accepted
    start32(32'd100, 32'd3, 32'd1, 1'b1);
    repeat (8) @(negedge clock);
    start32(32'd9, 32'd9, 32'd9, 1'b0);
    for (int n = 0; n < 100 && !bus32.done; n++) @(negedge clock);
    check("t3_done_seen", 64'(bus32.done), 64'd1);
    start32(32'd9, 32'd9, 32'd9, 1'b1);
    wait32();
    check("t3_second", bus32.product, 64'd90);

    // reset mid-operation discards it
    start32(32'd1000, 32'd1000, 32'd0, 1'b1);
    repeat (12) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    q32.delete();
    last32 = '0;
    last8  = '0;
    @(negedge clock);
    reset = 1'b1;
    check("t4_busy", 64'(bus32.busy), 64'd0);
    check("t4_done", 64'(bus32.done), 64'd0);
    check("t4_prod", bus32.product, 64'd0);
    repeat (40) @(negedge clock);
    start32(32'd1000, 32'd1000, 32'd0, 1'b1);
    wait32();
    check("t4_after", bus32.product, 64'd1000000);

    // divider round trip: quotient*divisor+rest rebuilds the dividend
    for (int i = 0; i < 1000; i++) begin
      dvd = $urandom;
      dvs = $urandom >> $urandom_range(0, 31);
      if (dvs == 32'd0) dvs = 32'd1;
      start32(dvd / dvs, dvs, dvd % dvs, 1'b1);
      wait32();
      check("t5_roundtrip", bus32.product, {32'd0, dvd});
    end

    // 8-bit instance
    start8(8'd255, 8'd255, 8'd255);
    wait8();
    check("t6_max8", 64'(bus8.product), 64'h0000_0000_0000_FF00);
    start8(8'd13, 8'd11, 8'd2);
    wait8();
    check("t6_small8", 64'(bus8.product), 64'd145);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
